// File: rtl/mac_pkg.sv
// Shared definitions for the MAC launch / done-count handshake.
//   launch_state_t    : launcher FSM state encoding (2-bit)
//   NumOpsDefault     : launches per batch; the done counter's terminal count uses the same value
//   CntWDefault       : issue index width for the default batch size
//   TimeoutCycDefault : default WAIT-state cycle limit for the optional timeout
package mac_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StFin   = 2'd3
  } launch_state_t;

  localparam int unsigned NumOpsDefault     = 14;
  localparam int unsigned CntWDefault       = 4;
  localparam int unsigned TimeoutCycDefault = 64;

endpackage

// File: rtl/wait_timer.sv
// WAIT-state timeout counter for mac_launcher (only instantiated with LAUNCH_TIMEOUT_EN).
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset
//   clr_i     : clear the count (asserted on the edge that enters WAIT)
//   en_i      : count this cycle (high while in WAIT)
//   expired_o : high in the WAIT cycle whose closing edge completes Limit WAIT cycles
module wait_timer #(
  parameter int unsigned Limit = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(Limit + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // cnt_q counts WAIT cycles already closed, so the Limit-th cycle sees Limit-1.
  assign expired_o = en_i && (cnt_q == W'(Limit - 1));

endmodule

// File: rtl/mac_launcher.sv
// Issue side of the MAC done-counting handshake: emits NUM_OPS mac_go pulses per batch,
// then waits for the batch-complete strobe en_y from the done counter.
// Optional feature macro: LAUNCH_TIMEOUT_EN (WAIT-state timeout with sticky timeout_err).
//   clk         : system clock, rising edge
//   reset       : asynchronous active-high reset
//   start       : begin a batch (sampled only in IDLE)
//   stall       : array back-pressure, suppresses issue for the cycle
//   en_y        : batch-complete strobe (only honoured in WAIT)
//   mac_go      : one-cycle launch pulse
//   mac_idx     : index of the launch on mac_go (pending index while stalled)
//   busy        : high in every state except IDLE
//   batch_done  : one-cycle pulse in FIN
//   timeout_err : sticky WAIT timeout flag (constant 0 without LAUNCH_TIMEOUT_EN)
module mac_launcher
  import mac_pkg::*;
#(
  parameter int unsigned NUM_OPS     = NumOpsDefault,
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             en_y,
  output logic             mac_go,
  output logic [CNT_W-1:0] mac_idx,
  output logic             busy,
  output logic             batch_done,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_OPS - 1);

  if ((1 << CNT_W) <= NUM_OPS) begin : g_bad_cnt_w
    $error("CNT_W is too narrow to hold NUM_OPS-1");
  end
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be nonzero");
  end

  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c);
    return (c == LastIdx) ? '0 : c + CNT_W'(1);
  endfunction

  launch_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mac_go_q;
  logic [CNT_W-1:0] mac_idx_q;
  logic             busy_q;
  logic             batch_done_q;
  logic             final_out;
  logic             wait_expired;

  // Outputs are registered one edge ahead of the state, so the pulse for the last launch is on
  // the outputs while the FSM is still in ISSUE; WAIT is entered on the edge that closes it.
  assign final_out = (state_q == StIssue) && mac_go_q && (mac_idx_q == LastIdx);

`ifdef LAUNCH_TIMEOUT_EN
  logic timeout_q;

  wait_timer #(
    .Limit(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk_i    (clk),
    .rst_i    (reset),
    .clr_i    (final_out),
    .en_i     (state_q == StWait),
    .expired_o(wait_expired)
  );

  assign timeout_err = timeout_q;
`else
  assign wait_expired = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      mac_go_q     <= 1'b0;
      mac_idx_q    <= '0;
      busy_q       <= 1'b0;
      batch_done_q <= 1'b0;
`ifdef LAUNCH_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      mac_go_q     <= 1'b0;
      batch_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StIssue;
            busy_q    <= 1'b1;
            mac_idx_q <= '0;
`ifdef LAUNCH_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            // Launch 0 goes out in the first ISSUE cycle unless that cycle is stalled.
            if (!stall) begin
              mac_go_q <= 1'b1;
              cnt_q    <= next_cnt('0);
            end else begin
              cnt_q    <= '0;
            end
          end
        end
        StIssue: begin
          if (final_out) begin
            state_q <= StWait;
          end else begin
            // While stalled mac_idx shows the pending index and the count holds.
            mac_idx_q <= cnt_q;
            if (!stall) begin
              mac_go_q <= 1'b1;
              cnt_q    <= next_cnt(cnt_q);
            end
          end
        end
        StWait: begin
          if (en_y) begin
            state_q      <= StFin;
            batch_done_q <= 1'b1;
          end else if (wait_expired) begin
            state_q      <= StFin;
            batch_done_q <= 1'b1;
`ifdef LAUNCH_TIMEOUT_EN
            timeout_q    <= 1'b1;
`endif
          end
        end
        StFin: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mac_go     = mac_go_q;
  assign mac_idx    = mac_idx_q;
  assign busy       = busy_q;
  assign batch_done = batch_done_q;

endmodule

// File: tb/tb_mac_launcher.sv
// Self-checking bench for mac_launcher: a batch-level reference model pushes the expected
// outputs of every cycle into a queue; a monitor pops and compares them against the DUT.
module tb_mac_launcher;

  localparam int NOPS = 14;
  localparam int CW   = 4;
`ifdef LAUNCH_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 64;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          en_y  = 1'b0;
  logic          mac_go;
  logic [CW-1:0] mac_idx;
  logic          busy;
  logic          batch_done;
  logic          timeout_err;

  mac_launcher #(
    .NUM_OPS    (NOPS),
    .CNT_W      (CW),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .en_y       (en_y),
    .mac_go     (mac_go),
    .mac_idx    (mac_idx),
    .busy       (busy),
    .batch_done (batch_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit go;
    int idx;
    bit chk_idx;
    bit busy;
    bit done;
    bit terr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   go_cnt = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;

  // Reference model: a batch is "launch 0..NOPS-1 in order, skipping stalled cycles, then wait
  // for en_y (seen only after the last launch cycle has passed), then one done cycle".
  bit m_in = 0, m_wait = 0, m_fin = 0, m_terr = 0;
  int m_launched = 0, m_wcnt = 0;

  always @(posedge clk) begin : model
    exp_t e;
    bit   iss;
    e   = '{go: 0, idx: 0, chk_idx: 0, busy: 0, done: 0, terr: 0};
    iss = 0;
    if (reset) begin
      m_in = 0; m_wait = 0; m_fin = 0; m_terr = 0;
      e.chk_idx = 1;
    end else begin
      if (!m_in) begin
        if (start) begin
          m_in = 1; m_launched = 0; m_wait = 0; m_fin = 0; m_terr = 0;
          iss = 1;
        end
      end else if (m_fin) begin
        m_in = 0; m_fin = 0;
      end else if (m_wait) begin
        if (en_y) begin
          e.done = 1; m_fin = 1;
        end else begin
          m_wcnt++;
`ifdef LAUNCH_TIMEOUT_EN
          if (m_wcnt == TO_CYC) begin
            e.done = 1; m_fin = 1; m_terr = 1;
          end
`endif
        end
      end else if (m_launched == NOPS) begin
        m_wait = 1; m_wcnt = 0;
      end else begin
        iss = 1;
      end
      if (iss) begin
        e.chk_idx = 1;
        e.idx     = m_launched;
        if (!stall) begin
          e.go = 1;
          m_launched++;
        end
      end
      e.busy = m_in;
      e.terr = m_terr;
    end
    exp_q.push_back(e);
  end

  // Monitor: one expected entry per clock cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cycle_expect t=%0t: no expected entry queued", $time);
      end else begin
        e = exp_q.pop_front();
        if (mac_go !== e.go || busy !== e.busy || batch_done !== e.done ||
            timeout_err !== e.terr || (e.chk_idx && mac_idx !== CW'(e.idx))) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t: got go=%b idx=%0d busy=%b done=%b terr=%b, expected go=%b idx=%0d(chk=%b) busy=%b done=%b terr=%b",
                   $time, mac_go, mac_idx, busy, batch_done, timeout_err,
                   e.go, e.idx, e.chk_idx, e.busy, e.done, e.terr);
        end
      end
      if (mac_go === 1'b1) go_cnt++;
      if (batch_done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
  end

  task automatic cyc(input logic s, input logic st, input logic e);
    @(negedge clk);
    start = s;
    stall = st;
    en_y  = e;
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  initial begin : stim
    int go0, done0, busy0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: plain batch, en_y 5 cycles after the last launch.
    go0 = go_cnt; done0 = done_cnt; busy0 = busy_cnt;
    cyc(1, 0, 0);
    repeat (18) cyc(0, 0, 0);
    cyc(0, 0, 1);
    repeat (4) cyc(0, 0, 0);
    check_val("t1_go_pulses", go_cnt - go0, NOPS);
    check_val("t1_done_pulses", done_cnt - done0, 1);
    check_val("t1_busy_cycles", busy_cnt - busy0, NOPS + 5 + 1);

    // 2: stall in ISSUE cycles 3..5.
    go0 = go_cnt; done0 = done_cnt;
    cyc(1, 0, 0);
    for (int j = 1; j <= 24; j++) cyc(0, (j >= 3 && j <= 5), (j == 19));
    check_val("t2_go_pulses", go_cnt - go0, NOPS);
    check_val("t2_done_pulses", done_cnt - done0, 1);

    // 3: start while busy and en_y during ISSUE must not complete the batch.
    go0 = go_cnt; done0 = done_cnt;
    cyc(1, 0, 0);
    for (int j = 1; j <= 24; j++) begin
      cyc((j == 5 || j == 16 || j == 17), 0, (j == 5 || j == 10 || j == 19));
      if (j == 18) check_val("t3_no_early_done", done_cnt - done0, 0);
    end
    check_val("t3_go_pulses", go_cnt - go0, NOPS);
    check_val("t3_done_pulses", done_cnt - done0, 1);

    // 4: asynchronous reset while launch 7 is on the outputs.
    cyc(1, 0, 0);
    repeat (8) cyc(0, 0, 0);
    #2 reset = 1'b1;
    #1;
    check_val("t4_rst_mac_go", int'(mac_go), 0);
    check_val("t4_rst_mac_idx", int'(mac_idx), 0);
    check_val("t4_rst_busy", int'(busy), 0);
    check_val("t4_rst_batch_done", int'(batch_done), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    go0 = go_cnt; done0 = done_cnt;
    cyc(1, 0, 0);
    repeat (18) cyc(0, 0, 0);
    cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 0);
    check_val("t4_restart_go_pulses", go_cnt - go0, NOPS);
    check_val("t4_restart_done", done_cnt - done0, 1);

    // 5: start held for three batches, en_y 2 cycles after each WAIT entry.
    go0 = go_cnt; done0 = done_cnt; busy0 = busy_cnt;
    for (int j = 0; j < 57; j++) cyc(1, 0, (j % 19 == 17));
    repeat (4) cyc(0, 0, 0);
    check_val("t5_go_pulses", go_cnt - go0, 3 * NOPS);
    check_val("t5_done_pulses", done_cnt - done0, 3);
    check_val("t5_busy_cycles", busy_cnt - busy0, 3 * 18);

    // Randomized traffic, then drain any open batch.
    for (int j = 0; j < 400; j++)
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0));
    repeat (40) cyc(0, 0, 1);
    repeat (2) cyc(0, 0, 0);

`ifdef LAUNCH_TIMEOUT_EN
    // 6: no en_y -> timeout after TO_CYC WAIT cycles; next start clears the flag.
    done0 = done_cnt;
    cyc(1, 0, 0);
    repeat (30) cyc(0, 0, 0);
    check_val("t6_timeout_err_set", int'(timeout_err), 1);
    check_val("t6_timeout_done", done_cnt - done0, 1);
    check_val("t6_timeout_idle", int'(busy), 0);
    cyc(1, 0, 0);
    for (int j = 1; j <= 22; j++) begin
      cyc(0, 0, (j == 17));
      if (j == 1) check_val("t6_timeout_err_cleared", int'(timeout_err), 0);
    end
    check_val("t6_err_stays_clear", int'(timeout_err), 0);
`else
    // 6: without the timeout feature WAIT lasts until en_y.
    done0 = done_cnt;
    cyc(1, 0, 0);
    repeat (100) cyc(0, 0, 0);
    check_val("t6_wait_still_busy", int'(busy), 1);
    check_val("t6_wait_no_done", done_cnt - done0, 0);
    check_val("t6_no_timeout_err", int'(timeout_err), 0);
    cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 0);
    check_val("t6_wait_done", done_cnt - done0, 1);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_launcher.md
Name: mac_launcher

Overview:
- Issue side of the MAC done-counting handshake: emits one `mac_go` pulse per MAC operation of a batch, then waits for the batch-complete strobe `en_y` produced by the done counter.
- Sits between the top-level control and the systolic MAC array.
- Guarantees exactly NUM_OPS launches per batch, so the downstream done count is consistent.

Parameters:
- NUM_OPS, 14, launches per batch; must equal the done-counter terminal count.
- CNT_W, 4, width of the issue index; must satisfy 2**CNT_W > NUM_OPS.
- TIMEOUT_CYC, 64, WAIT-state cycle limit (used only with LAUNCH_TIMEOUT_EN).

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, begin a batch; sampled only in IDLE.
- stall, input, 1, array back-pressure; suppresses issue in the cycle it is high.
- en_y, input, 1, batch-complete strobe from the done counter.
- mac_go, output, 1, one-cycle launch pulse to the MAC array.
- mac_idx, output, CNT_W, index of the launch currently on `mac_go`.
- busy, output, 1, high in every state except IDLE.
- batch_done, output, 1, one-cycle pulse when the batch completes.
- timeout_err, output, 1, sticky error flag; constant 0 unless LAUNCH_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, issue count=0, and mac_go, mac_idx, busy, batch_done, timeout_err all 0. Any in-flight batch is abandoned; no further pulses are emitted.
- All outputs are registered (driven from flops).
- State encoding is a 2-bit enum: IDLE, ISSUE, WAIT, FIN.
- IDLE:
  - start=1 -> ISSUE on the next edge, with issue count=0.
  - en_y is ignored.
- ISSUE:
  - Each cycle with stall=0: mac_go=1 and mac_idx=current count; count increments.
  - Each cycle with stall=1: mac_go=0, mac_idx holds, count holds.
  - When launch NUM_OPS-1 is issued, go to WAIT on the next edge; count returns to 0.
  - Latency: the first mac_go appears one cycle after start is sampled. An unstalled batch occupies exactly NUM_OPS consecutive cycles.
- WAIT:
  - mac_go=0.
  - en_y=1 -> FIN.
  - en_y arriving in ISSUE, or in the same cycle as the final launch, is ignored. Only en_y seen while in WAIT completes the batch.
- FIN: batch_done=1 for exactly one cycle, then IDLE.
- busy=1 in ISSUE, WAIT and FIN.
- start while busy is ignored; it is not queued.
- start high continuously produces back-to-back batches, separated by one IDLE cycle.
- stall in WAIT or FIN has no effect.
- Issue count wraps only through the explicit return to 0; it never exceeds NUM_OPS-1.

Optional Feature:
- Macro: LAUNCH_TIMEOUT_EN.
- Defined:
  - A wait counter of width $clog2(TIMEOUT_CYC+1) clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without en_y: timeout_err is set, and the block goes to FIN (batch_done still pulses) and then IDLE.
  - If en_y arrives in the same cycle the limit is reached, en_y wins and timeout_err stays 0.
  - timeout_err is cleared when start is accepted in IDLE, and by reset.
- Not defined: no wait counter exists, timeout_err is tied 0, and WAIT lasts indefinitely.

Decomposition:
- Shared package `mac_pkg`:
  - launch_state_t enum.
  - NUM_OPS default constant, shared with the done counter so both ends agree.
- Natural sub-module: `wait_timer`, the timeout counter, instantiated only under LAUNCH_TIMEOUT_EN.
- The FSM and issue counter stay in the top module.

Test Plan:
- start pulse, stall=0, en_y 5 cycles after the last launch -> mac_go high 14 consecutive cycles with mac_idx 0..13; batch_done exactly 1 cycle after en_y; busy for 14+5+1 cycles.
- stall=1 for cycles 3-5 of ISSUE -> mac_go low for those 3 cycles, mac_idx holds at 3, still exactly 14 pulses, and idx 13 is delayed by 3 cycles.
- start reasserted during ISSUE and WAIT, plus en_y pulsed during ISSUE -> no extra batch and no early batch_done; completion occurs only on en_y in WAIT.
- reset asserted mid-ISSUE at idx 7 (asynchronously, between edges) -> all outputs 0 immediately; after release, a new start restarts at idx 0.
- start held high for 3 batches, with en_y returned 2 cycles after each WAIT entry -> 42 total mac_go pulses, 3 batch_done pulses, 1 IDLE cycle between batches.
- LAUNCH_TIMEOUT_EN, TIMEOUT_CYC=8, no en_y -> timeout_err=1 after 8 WAIT cycles, batch_done pulses, return to IDLE; next start clears timeout_err.
